// File: rtl/swd_target_emu_if.sv
// SWD wire plus transfer-report bundle between a host (master) and swd_target_emu (slave).
interface swd_target_emu_if;
  logic        swclk;
  logic        swdio_i;
  logic        swdio_o;
  logic        swdio_t;
  logic        xfer_done;
  logic        xfer_rnw;
  logic [2:0]  xfer_addr;
  logic [31:0] xfer_data;
  logic        line_reset;
  logic [7:0]  err_cnt;

  modport slave (
    input  swclk, swdio_i,
    output swdio_o, swdio_t, xfer_done, xfer_rnw, xfer_addr, xfer_data, line_reset, err_cnt
  );

  modport master (
    output swclk, swdio_i,
    input  swdio_o, swdio_t, xfer_done, xfer_rnw, xfer_addr, xfer_data, line_reset, err_cnt
  );
endinterface

// File: rtl/swd_target_emu.sv
// SWD target emulator: oversamples SWCLK, decodes headers and serves eight 32-bit registers.
// Optional WAIT injection is compiled in with SWD_EMU_WAIT_INJECT_EN.
module swd_target_emu #(
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned WAIT_COUNT  = 2,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input logic             clk,
  input logic             resetn,
  swd_target_emu_if.slave bus
);
  localparam logic [2:0] AckOk    = 3'b001;
  localparam logic [2:0] AckFault = 3'b100;
  localparam logic [5:0] TurnLast = 6'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StHdr, StTurn1, StAck, StRdata, StTurn2, StWdata} state_e;

  state_e      state_q;
  logic [2:0]  sync_q;
  logic        tick;
  logic [5:0]  ones_q, ones_d;
  logic        lr_hit;
  logic [5:0]  bit_q;
  logic [6:0]  hdr_q, hdr_nx;
  logic        hdr_ok, abort_hdr;
  logic [2:0]  ack_q, ack_sel, addr;
  logic [31:0] data_q;
  logic [31:0] regs_q [8];
  logic        sticky_q, done_pend_q;
  logic        swdio_o_q, swdio_t_q, xfer_done_q, xfer_rnw_q, line_reset_q;
  logic [2:0]  xfer_addr_q;
  logic [31:0] xfer_data_q;
  logic [7:0]  err_q, err_inc;
`ifdef SWD_EMU_WAIT_INJECT_EN
  localparam logic [2:0] AckWait = 3'b010;
  logic [7:0] wait_q;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[1:0], bus.swclk};
  end

  assign tick      = sync_q[1] & ~sync_q[2];
  assign hdr_nx    = {bus.swdio_i, hdr_q[6:1]};
  assign hdr_ok    = (hdr_nx[4] == ^hdr_nx[3:0]) && !hdr_nx[5] && hdr_nx[6];
  assign abort_hdr = (hdr_nx[3:0] == 4'b0000);
  assign addr      = {hdr_q[0], hdr_q[3], hdr_q[2]};
  assign err_inc   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  assign lr_hit    = tick && bus.swdio_i && (ones_q == 6'd49);

  always_comb begin
    ones_d = ones_q;
    if (tick) begin
      if (!bus.swdio_i)           ones_d = '0;
      else if (ones_q != 6'd63)   ones_d = ones_q + 6'd1;
    end
  end

  // FAULT outranks WAIT; an ABORT header is let through so sticky_err can be cleared.
  always_comb begin
    ack_sel = AckOk;
    if (sticky_q && !abort_hdr) ack_sel = AckFault;
`ifdef SWD_EMU_WAIT_INJECT_EN
    else if (wait_q < 8'(WAIT_COUNT)) ack_sel = AckWait;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      ones_q       <= '0;
      bit_q        <= '0;
      hdr_q        <= '0;
      ack_q        <= '0;
      data_q       <= '0;
      regs_q       <= '{default: RESET_VAL};
      sticky_q     <= 1'b0;
      done_pend_q  <= 1'b0;
      swdio_o_q    <= 1'b0;
      swdio_t_q    <= 1'b1;
      xfer_done_q  <= 1'b0;
      xfer_rnw_q   <= 1'b0;
      xfer_addr_q  <= '0;
      xfer_data_q  <= '0;
      line_reset_q <= 1'b0;
      err_q        <= '0;
`ifdef SWD_EMU_WAIT_INJECT_EN
      wait_q       <= '0;
`endif
    end else begin
      xfer_done_q  <= 1'b0;
      line_reset_q <= 1'b0;
      ones_q       <= ones_d;
      if (tick && done_pend_q) begin
        done_pend_q <= 1'b0;
        xfer_done_q <= 1'b1;
        xfer_rnw_q  <= hdr_q[1];
        xfer_addr_q <= addr;
        xfer_data_q <= data_q;
      end
      if (lr_hit) begin
        state_q      <= StIdle;
        swdio_t_q    <= 1'b1;
        swdio_o_q    <= 1'b0;
        line_reset_q <= 1'b1;
      end else if (tick) begin
        unique case (state_q)
          StIdle: begin
            swdio_t_q <= 1'b1;
            // Ones beyond a line reset are not start bits.
            if (bus.swdio_i && ones_q < 6'd50) begin
              state_q <= StHdr;
              bit_q   <= '0;
            end
          end
          StHdr: begin
            hdr_q <= hdr_nx;
            bit_q <= bit_q + 6'd1;
            if (bit_q == 6'd6) begin
              bit_q <= '0;
              if (hdr_ok) begin
                state_q <= StTurn1;
                ack_q   <= ack_sel;
`ifdef SWD_EMU_WAIT_INJECT_EN
                if (ack_sel == AckWait) wait_q <= wait_q + 8'd1;
`endif
              end else begin
                state_q <= StIdle;
                err_q   <= err_inc;
              end
            end
          end
          StTurn1: begin
            swdio_t_q <= 1'b1;
            bit_q     <= bit_q + 6'd1;
            if (bit_q == TurnLast) begin
              state_q <= StAck;
              bit_q   <= '0;
            end
          end
          StAck: begin
            swdio_t_q <= 1'b0;
            swdio_o_q <= ack_q[bit_q[1:0]];
            bit_q     <= bit_q + 6'd1;
            if (bit_q == 6'd2) begin
              bit_q <= '0;
              if (ack_q == AckOk && hdr_q[1]) begin
                state_q <= StRdata;
                data_q  <= regs_q[addr];
              end else begin
                state_q <= StTurn2;
              end
            end
          end
          StRdata: begin
            swdio_t_q <= 1'b0;
            bit_q     <= bit_q + 6'd1;
            if (bit_q == 6'd32) begin
              swdio_o_q   <= ^data_q;
              state_q     <= StTurn2;
              bit_q       <= '0;
              done_pend_q <= 1'b1;
`ifdef SWD_EMU_WAIT_INJECT_EN
              wait_q      <= '0;
`endif
            end else begin
              swdio_o_q <= data_q[bit_q[4:0]];
            end
          end
          StTurn2: begin
            swdio_t_q <= 1'b1;
            swdio_o_q <= 1'b0;
            bit_q     <= bit_q + 6'd1;
            if (bit_q == TurnLast) begin
              bit_q   <= '0;
              state_q <= (ack_q == AckOk && !hdr_q[1]) ? StWdata : StIdle;
            end
          end
          StWdata: begin
            bit_q <= bit_q + 6'd1;
            if (bit_q == 6'd32) begin
              state_q <= StIdle;
              bit_q   <= '0;
              if (bus.swdio_i == ^data_q) begin
                regs_q[addr] <= data_q;
                done_pend_q  <= 1'b1;
                if (addr == 3'd0 && data_q[2]) sticky_q <= 1'b0;
`ifdef SWD_EMU_WAIT_INJECT_EN
                wait_q       <= '0;
`endif
              end else begin
                sticky_q <= 1'b1;
                err_q    <= err_inc;
              end
            end else begin
              data_q <= {bus.swdio_i, data_q[31:1]};
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.swdio_o    = swdio_o_q;
  assign bus.swdio_t    = swdio_t_q;
  assign bus.xfer_done  = xfer_done_q;
  assign bus.xfer_rnw   = xfer_rnw_q;
  assign bus.xfer_addr  = xfer_addr_q;
  assign bus.xfer_data  = xfer_data_q;
  assign bus.line_reset = line_reset_q;
  assign bus.err_cnt    = err_q;
endmodule
